// File: rtl/sparc_ifu_thrfsm_pkg.sv
// Shared state encodings and decode helpers for the IFU per-thread switch FSMs.
package sparc_ifu_thrfsm_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 5'b00000,
    ST_WAIT     = 5'b00001,
    ST_HALT     = 5'b00010,
    ST_RUN      = 5'b00101,
    ST_SPEC_RUN = 5'b00111,
    ST_SPEC_RDY = 5'b10011,
    ST_RDY      = 5'b11001
  } thr_state_e;

  function automatic logic is_rdy(input thr_state_e s);
    return (s == ST_RDY) || (s == ST_SPEC_RDY);
  endfunction

  function automatic logic is_run(input thr_state_e s);
    return (s == ST_RUN) || (s == ST_SPEC_RUN);
  endfunction

endpackage

// File: rtl/sparc_ifu_thrfsm_chan.sv
// One thread channel: next-state logic, state register, illegal-state decode and
// an optional WAIT watchdog built only when SPARC_IFU_THRFSM_WDOG_EN is defined.
module sparc_ifu_thrfsm_chan
  import sparc_ifu_thrfsm_pkg::*;
#(
  parameter int WDOG_W = 10
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               completion,
  input  logic               schedule,
  input  logic               spec_ld,
  input  logic               ldhit,
  input  logic               stall,
  input  logic               int_activate,
  input  logic               halt_thread,
  input  logic               start_thread,
  input  logic               nuke_thread,
  input  logic               thaw_thread,
  input  logic               rst_thread,
  input  logic               switch_out,
  input  logic               sw_cond,
  output logic [STATE_W-1:0] thr_state,
  output logic               rdy,
  output logic               run,
  output logic               wdog_to,
  output logic               illegal_state
);

  thr_state_e state_q;
  thr_state_e state_d;
  logic       illegal;

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_thread || thaw_thread)        state_d = ST_WAIT;
        else if (start_thread)                state_d = ST_RDY;
      end
      ST_HALT: begin
        if (nuke_thread)                      state_d = ST_IDLE;
        else if (rst_thread || thaw_thread)   state_d = ST_WAIT;
        else if (int_activate || start_thread) state_d = ST_RDY;
      end
      ST_RDY: begin
        if (stall)                            state_d = ST_WAIT;
        else if (schedule)                    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall || sw_cond)                 state_d = ST_WAIT;
        else if (switch_out)                  state_d = ST_RDY;
      end
      ST_WAIT: begin
        if (nuke_thread)                      state_d = ST_IDLE;
        else if (halt_thread)                 state_d = ST_HALT;
        else if (stall)                       state_d = ST_WAIT;
        else if (spec_ld)                     state_d = ST_SPEC_RDY;
        else if (completion)                  state_d = ST_RDY;
      end
      ST_SPEC_RDY: begin
        if (stall)                            state_d = ST_WAIT;
        else if (schedule && !ldhit)          state_d = ST_SPEC_RUN;
        else if (schedule && ldhit)           state_d = ST_RUN;
        else if (ldhit)                       state_d = ST_RDY;
      end
      ST_SPEC_RUN: begin
        if (stall || sw_cond)                 state_d = ST_WAIT;
        else if (ldhit && switch_out)         state_d = ST_RDY;
        else if (ldhit)                       state_d = ST_RUN;
        else if (switch_out)                  state_d = ST_SPEC_RDY;
      end
      default: begin
        // Corrupted state: only a thread reset or nuke can recover it.
        illegal = 1'b1;
        if (rst_thread)                       state_d = ST_WAIT;
        else if (nuke_thread)                 state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign thr_state     = state_q;
  assign rdy           = is_rdy(state_q);
  assign run           = is_run(state_q);
  assign illegal_state = illegal;

`ifdef SPARC_IFU_THRFSM_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic [WDOG_W-1:0] wdog_cnt_d;
  logic              wdog_to_q;
  logic              wdog_to_d;
  logic              stay_wait;

  // The flag sets one edge after the count saturates and drops as soon as WAIT is left.
  always_comb begin
    stay_wait  = (state_q == ST_WAIT) && (state_d == ST_WAIT);
    wdog_cnt_d = '0;
    wdog_to_d  = 1'b0;
    if (stay_wait) begin
      wdog_cnt_d = (&wdog_cnt_q) ? wdog_cnt_q : wdog_cnt_q + WDOG_W'(1);
      wdog_to_d  = wdog_to_q || (&wdog_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wdog_cnt_q <= '0;
      wdog_to_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_to_q  <= wdog_to_d;
    end
  end

  assign wdog_to = wdog_to_q;
`else
  localparam int wdog_w_unused = WDOG_W;
  assign wdog_to = 1'b0;
`endif

endmodule

// File: rtl/sparc_ifu_thrfsm_bank.sv
// Bank of NTHR independent thread FSM channels plus the bank-wide multi-run check.
// The WAIT watchdog is present only when SPARC_IFU_THRFSM_WDOG_EN is defined.
module sparc_ifu_thrfsm_bank
  import sparc_ifu_thrfsm_pkg::*;
#(
  parameter int NTHR   = 4,
  parameter int WDOG_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      se,
  input  logic                      si,
  output logic                      so,
  input  logic [NTHR-1:0]           completion,
  input  logic [NTHR-1:0]           schedule,
  input  logic [NTHR-1:0]           spec_ld,
  input  logic [NTHR-1:0]           ldhit,
  input  logic [NTHR-1:0]           stall,
  input  logic [NTHR-1:0]           int_activate,
  input  logic [NTHR-1:0]           halt_thread,
  input  logic [NTHR-1:0]           start_thread,
  input  logic [NTHR-1:0]           nuke_thread,
  input  logic [NTHR-1:0]           thaw_thread,
  input  logic [NTHR-1:0]           rst_thread,
  input  logic [NTHR-1:0]           switch_out,
  input  logic [NTHR-1:0]           sw_cond,
  output logic [STATE_W*NTHR-1:0]   thr_state,
  output logic [NTHR-1:0]           rdy_vec,
  output logic [NTHR-1:0]           run_vec,
  output logic [NTHR-1:0]           wdog_to,
  output logic [NTHR-1:0]           illegal_state,
  output logic                      multi_run_err
);

  logic scan_unused;
  assign scan_unused = se ^ si;
  assign so          = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NTHR; gi++) begin : g_chan
      sparc_ifu_thrfsm_chan #(
        .WDOG_W (WDOG_W)
      ) u_chan (
        .clk           (clk),
        .rst_l         (rst_l),
        .completion    (completion[gi]),
        .schedule      (schedule[gi]),
        .spec_ld       (spec_ld[gi]),
        .ldhit         (ldhit[gi]),
        .stall         (stall[gi]),
        .int_activate  (int_activate[gi]),
        .halt_thread   (halt_thread[gi]),
        .start_thread  (start_thread[gi]),
        .nuke_thread   (nuke_thread[gi]),
        .thaw_thread   (thaw_thread[gi]),
        .rst_thread    (rst_thread[gi]),
        .switch_out    (switch_out[gi]),
        .sw_cond       (sw_cond[gi]),
        .thr_state     (thr_state[STATE_W*gi +: STATE_W]),
        .rdy           (rdy_vec[gi]),
        .run           (run_vec[gi]),
        .wdog_to       (wdog_to[gi]),
        .illegal_state (illegal_state[gi])
      );
    end
  endgenerate

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_run_err = |(run_vec & (run_vec - NTHR'(1)));

endmodule

// File: tb/tb_sparc_ifu_thrfsm_bank.sv
// Directed plus randomized bench for sparc_ifu_thrfsm_bank against an abstract thread model.
module tb_sparc_ifu_thrfsm_bank;
  import sparc_ifu_thrfsm_pkg::*;

  localparam int NTHR   = 4;
  localparam int WDOG_W = 3;
`ifdef SPARC_IFU_THRFSM_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk, rst_l, se, si, so;
  logic [NTHR-1:0] completion, schedule, spec_ld, ldhit, stall, int_activate;
  logic [NTHR-1:0] halt_thread, start_thread, nuke_thread, thaw_thread, rst_thread;
  logic [NTHR-1:0] switch_out, sw_cond;
  logic [STATE_W*NTHR-1:0] thr_state;
  logic [NTHR-1:0] rdy_vec, run_vec, wdog_to, illegal_state;
  logic multi_run_err;

  sparc_ifu_thrfsm_bank #(.NTHR(NTHR), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .rst_l(rst_l), .se(se), .si(si), .so(so),
    .completion(completion), .schedule(schedule), .spec_ld(spec_ld), .ldhit(ldhit),
    .stall(stall), .int_activate(int_activate), .halt_thread(halt_thread),
    .start_thread(start_thread), .nuke_thread(nuke_thread), .thaw_thread(thaw_thread),
    .rst_thread(rst_thread), .switch_out(switch_out), .sw_cond(sw_cond),
    .thr_state(thr_state), .rdy_vec(rdy_vec), .run_vec(run_vec), .wdog_to(wdog_to),
    .illegal_state(illegal_state), .multi_run_err(multi_run_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {S_IDLE, S_HALT, S_RDY, S_RUN, S_WAIT, S_SRDY, S_SRUN, S_BAD} mst_t;
  mst_t mst [NTHR];
  int   wrun[NTHR];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] enc(input mst_t s);
    case (s)
      S_IDLE:  return 5'b00000;
      S_WAIT:  return 5'b00001;
      S_HALT:  return 5'b00010;
      S_RUN:   return 5'b00101;
      S_SRUN:  return 5'b00111;
      S_SRDY:  return 5'b10011;
      S_RDY:   return 5'b11001;
      default: return 5'b01111;
    endcase
  endfunction

  // Behavioural transition rules, first matching rule wins.
  function automatic mst_t nxt(input mst_t s, input int t);
    bit cm = completion[t], sc = schedule[t], sl = spec_ld[t], lh = ldhit[t];
    bit stl = stall[t], ia = int_activate[t], hl = halt_thread[t], st = start_thread[t];
    bit nk = nuke_thread[t], th = thaw_thread[t], rt = rst_thread[t];
    bit so_ = switch_out[t], swc = sw_cond[t];
    case (s)
      S_IDLE: begin if (rt | th) return S_WAIT; if (st) return S_RDY; end
      S_HALT: begin if (nk) return S_IDLE; if (rt | th) return S_WAIT; if (ia | st) return S_RDY; end
      S_RDY:  begin if (stl) return S_WAIT; if (sc) return S_RUN; end
      S_RUN:  begin if (stl | swc) return S_WAIT; if (so_) return S_RDY; end
      S_WAIT: begin
        if (nk) return S_IDLE; if (hl) return S_HALT; if (stl) return S_WAIT;
        if (sl) return S_SRDY; if (cm) return S_RDY;
      end
      S_SRDY: begin
        if (stl) return S_WAIT; if (sc && !lh) return S_SRUN; if (sc && lh) return S_RUN;
        if (lh) return S_RDY;
      end
      S_SRUN: begin
        if (stl | swc) return S_WAIT; if (lh && so_) return S_RDY; if (lh) return S_RUN;
        if (so_) return S_SRDY;
      end
      default: begin if (rt) return S_WAIT; if (nk) return S_IDLE; end
    endcase
    return s;
  endfunction

  task automatic model_edge();
    for (int t = 0; t < NTHR; t++) begin
      if (!rst_l) begin
        mst[t] = S_IDLE; wrun[t] = 0;
      end else begin
        mst_t n = nxt(mst[t], t);
        wrun[t] = (mst[t] == S_WAIT && n == S_WAIT) ? wrun[t] + 1 : 0;
        mst[t]  = n;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [STATE_W*NTHR-1:0] es;
    logic [NTHR-1:0] er, eu, ew, ei;
    for (int t = 0; t < NTHR; t++) begin
      es[STATE_W*t +: STATE_W] = enc(mst[t]);
      er[t] = (mst[t] == S_RDY) || (mst[t] == S_SRDY);
      eu[t] = (mst[t] == S_RUN) || (mst[t] == S_SRUN);
      ew[t] = WD_EN && (mst[t] == S_WAIT) && (wrun[t] >= (1 << WDOG_W));
      ei[t] = (mst[t] == S_BAD);
    end
    check_eq({tag, " thr_state"}, 32'(thr_state), 32'(es));
    check_eq({tag, " rdy_vec"}, 32'(rdy_vec), 32'(er));
    check_eq({tag, " run_vec"}, 32'(run_vec), 32'(eu));
    check_eq({tag, " wdog_to"}, 32'(wdog_to), 32'(ew));
    check_eq({tag, " illegal"}, 32'(illegal_state), 32'(ei));
    check_eq({tag, " multi_run"}, 32'(multi_run_err), 32'($countones(eu) > 1));
  endtask

  task automatic clr_in();
    completion = '0; schedule = '0; spec_ld = '0; ldhit = '0; stall = '0;
    int_activate = '0; halt_thread = '0; start_thread = '0; nuke_thread = '0;
    thaw_thread = '0; rst_thread = '0; switch_out = '0; sw_cond = '0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    clr_in();
  endtask

  initial begin
    int den;
    se = 1'b0; si = 1'b0; rst_l = 1'b0;
    clr_in();
    for (int t = 0; t < NTHR; t++) begin mst[t] = S_BAD; wrun[t] = 0; end
    @(negedge clk);
    step("reset"); step("reset");
    rst_l = 1'b1;

    start_thread[0] = 1'b1; step("t0_start");
    check_eq("t0_rdy_enc", 32'(thr_state[4:0]), 32'h19);
    check_eq("t0_rdy_vec", 32'(rdy_vec), 32'h1);
    schedule[0] = 1'b1; step("t0_sched");
    check_eq("t0_run_enc", 32'(thr_state[4:0]), 32'h05);
    check_eq("t0_run_vec", 32'(run_vec), 32'h1);

    thaw_thread[1] = 1'b1; step("t1_wait");
    nuke_thread[1] = 1'b1; halt_thread[1] = 1'b1; step("t1_nuke_halt");
    check_eq("t1_nuke_wins", 32'(thr_state[9:5]), 32'h00);
    thaw_thread[1] = 1'b1; step("t1_wait2");
    halt_thread[1] = 1'b1; step("t1_halt");
    check_eq("t1_halt_enc", 32'(thr_state[9:5]), 32'h02);

    thaw_thread[2] = 1'b1; step("t2_wait");
    spec_ld[2] = 1'b1; step("t2_spec_ld");
    check_eq("t2_srdy_enc", 32'(thr_state[14:10]), 32'h13);
    schedule[2] = 1'b1; step("t2_sched");
    check_eq("t2_srun_enc", 32'(thr_state[14:10]), 32'h07);
    ldhit[2] = 1'b1; switch_out[2] = 1'b1; step("t2_ldhit_sw");
    check_eq("t2_rdy_enc", 32'(thr_state[14:10]), 32'h19);

    thaw_thread[3] = 1'b1; step("t3_wait");
    for (int i = 1; i <= 8; i++) begin
      step("t3_hold");
      check_eq("wdog_rise", 32'(wdog_to[3]), (i == 8) ? 32'(WD_EN) : 32'h0);
    end
    completion[3] = 1'b1; step("t3_complete");
    check_eq("wdog_clear", 32'(wdog_to[3]), 32'h0);

    start_thread[1] = 1'b1; step("t1_start");
    schedule[1] = 1'b1; step("t1_sched");
    check_eq("multi_run", 32'(multi_run_err), 32'h1);
    stall[1] = 1'b1; step("t1_stall");
    check_eq("multi_run_clr", 32'(multi_run_err), 32'h0);

    stall[3] = 1'b1; step("t3_stall");
    for (int i = 0; i < 7; i++) step("t3_hold2");
    rst_l = 1'b0; step("mid_reset");
    check_eq("reset_state", 32'(thr_state), 32'h0);
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) step("post_reset");

    force dut.g_chan[0].u_chan.state_q = thr_state_e'(5'b01111);
    mst[0] = S_BAD;
    #1;
    check_all("forced");
    check_eq("illegal_vec", 32'(illegal_state), 32'h1);
    rst_thread[0] = 1'b1;
    release dut.g_chan[0].u_chan.state_q;
    step("illegal_rst");
    check_eq("illegal_to_wait", 32'(thr_state[4:0]), 32'h01);

    den = 4;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) den = ($urandom_range(0, 1) != 0) ? 4 : 30;
      rst_l = ($urandom_range(0, 199) != 0);
      for (int t = 0; t < NTHR; t++) begin
        completion[t]   = ($urandom_range(0, den) == 0);
        schedule[t]     = ($urandom_range(0, den) == 0);
        spec_ld[t]      = ($urandom_range(0, den) == 0);
        ldhit[t]        = ($urandom_range(0, den) == 0);
        stall[t]        = ($urandom_range(0, 2 * den) == 0);
        int_activate[t] = ($urandom_range(0, den) == 0);
        halt_thread[t]  = ($urandom_range(0, den) == 0);
        start_thread[t] = ($urandom_range(0, den) == 0);
        nuke_thread[t]  = ($urandom_range(0, 2 * den) == 0);
        thaw_thread[t]  = ($urandom_range(0, den) == 0);
        rst_thread[t]   = ($urandom_range(0, 2 * den) == 0);
        switch_out[t]   = ($urandom_range(0, den) == 0);
        sw_cond[t]      = ($urandom_range(0, 2 * den) == 0);
      end
      step("rand");
    end
    rst_l = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
